// File: rtl/conv_fifo_wr_packer_if.sv
// Pixel stream in, packed FIFO write port out, bundled for the write-domain packer.
// No logic of its own; timing is set entirely by the packer and its peers.
// Backpressure: s_ready for the pixel side, fifo_full (combinational) for the FIFO side.
interface conv_fifo_wr_packer_if #(
  parameter int PIX_WIDTH = 8,
  parameter int PACK      = 4
);
  localparam int W = PIX_WIDTH * PACK;

  logic                 s_valid;
  logic                 s_ready;
  logic [PIX_WIDTH-1:0] s_data;
  logic                 s_last;
  logic                 fifo_wr_en;
  logic [W-1:0]         fifo_wr_data;
  logic                 fifo_full;

  // Packer side: consumes pixels, produces FIFO writes
  modport slave (
    input  s_valid, s_data, s_last, fifo_full,
    output s_ready, fifo_wr_en, fifo_wr_data
  );

  // Environment side: produces pixels, models the FIFO full flag
  modport master (
    output s_valid, s_data, s_last, fifo_full,
    input  s_ready, fifo_wr_en, fifo_wr_data
  );
endinterface

// File: rtl/conv_fifo_wr_packer.sv
// Packs PACK pixels (pixel 0 in LSBs) into one FIFO word, pads/flushes a partial word on s_last.
// Latency: completing pixel accepted at edge N -> fifo_wr_en high in cycle N+1; 1 pixel/cycle sustained.
// Backpressure: out word held stable while fifo_full; s_ready drops once the out reg is occupied and full.
// Optional statistics counters enabled by defining WR_PACKER_STATS_EN.
module conv_fifo_wr_packer #(
  parameter int                   PIX_WIDTH  = 8,
  parameter int                   PACK       = 4,
  parameter logic [PIX_WIDTH-1:0] PAD_VALUE  = '0,
  parameter int                   STAT_WIDTH = 16
) (
  input  logic                    wr_clk,
  input  logic                    wr_rstn,
  input  logic                    i_clr,
  conv_fifo_wr_packer_if.slave    s_if,
  output logic                    o_frame_done,
  output logic                    o_busy,
  output logic [STAT_WIDTH-1:0]   o_stall_cnt,
  output logic [STAT_WIDTH-1:0]   o_word_cnt
);

  localparam int W  = PIX_WIDTH * PACK;
  localparam int LW = $clog2(PACK);

  // Output register is either empty or holding a word waiting for the FIFO
  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_HOLD  = 1'b1
  } out_state_e;

  out_state_e                     r_state;
  out_state_e                     w_state_nxt;
  logic [LW-1:0]                  r_lane_cnt;
  logic [PACK-1:0][PIX_WIDTH-1:0] r_asm;
  logic [W-1:0]                   r_out_dat;
  logic                           r_out_last;
  logic                           r_frame_done;

  logic                           w_wr_fire;
  logic                           w_s_ready;
  logic                           w_s_fire;
  logic                           w_lane_top;
  logic                           w_word_done;
  logic [W-1:0]                   w_word;

  // A pixel may enter whenever the out reg is free or drains this cycle, so the
  // completing pixel of the next word never has to wait on a writing word.
  assign w_wr_fire   = (r_state == OUT_HOLD) && !s_if.fifo_full;
  assign w_s_ready   = (r_state == OUT_EMPTY) || !s_if.fifo_full;
  assign w_s_fire    = s_if.s_valid && w_s_ready;
  assign w_lane_top  = (r_lane_cnt == LW'(PACK - 1));
  assign w_word_done = w_s_fire && (w_lane_top || s_if.s_last);

  // Completed word: stored lanes below the current one, the incoming pixel, pad above
  always_comb begin
    w_word = '0;
    for (int i = 0; i < PACK; i++) begin
      if (i < int'(r_lane_cnt)) begin
        w_word[i*PIX_WIDTH +: PIX_WIDTH] = r_asm[i];
      end else if (i == int'(r_lane_cnt)) begin
        w_word[i*PIX_WIDTH +: PIX_WIDTH] = s_if.s_data;
      end else begin
        w_word[i*PIX_WIDTH +: PIX_WIDTH] = PAD_VALUE;
      end
    end
  end

  // Out-reg state register
  always_ff @(posedge wr_clk or negedge wr_rstn) begin
    if (!wr_rstn) begin
      r_state <= OUT_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Out-reg next state: clear first, a new word keeps it full even while the old one drains
  always_comb begin
    w_state_nxt = r_state;
    if (i_clr) begin
      w_state_nxt = OUT_EMPTY;
    end else if (w_word_done) begin
      w_state_nxt = OUT_HOLD;
    end else if (w_wr_fire) begin
      w_state_nxt = OUT_EMPTY;
    end
  end

  // Lane assembly and output word load
  always_ff @(posedge wr_clk or negedge wr_rstn) begin
    if (!wr_rstn) begin
      r_lane_cnt <= '0;
      r_asm      <= '0;
      r_out_dat  <= '0;
      r_out_last <= 1'b0;
    end else if (i_clr) begin
      r_lane_cnt <= '0;
      r_asm      <= '0;
      r_out_dat  <= '0;
      r_out_last <= 1'b0;
    end else if (w_s_fire) begin
      r_asm[r_lane_cnt] <= s_if.s_data;
      if (w_word_done) begin
        r_lane_cnt <= '0;
        r_out_dat  <= w_word;
        r_out_last <= s_if.s_last;
      end else begin
        r_lane_cnt <= r_lane_cnt + LW'(1);
      end
    end
  end

  // Frame-done pulse follows the write of the word that carried s_last
  always_ff @(posedge wr_clk or negedge wr_rstn) begin
    if (!wr_rstn) begin
      r_frame_done <= 1'b0;
    end else if (i_clr) begin
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_wr_fire && r_out_last;
    end
  end

  assign s_if.s_ready      = w_s_ready;
  assign s_if.fifo_wr_en   = (r_state == OUT_HOLD);
  assign s_if.fifo_wr_data = r_out_dat;
  assign o_frame_done      = r_frame_done;
  assign o_busy            = (r_lane_cnt != '0) || (r_state == OUT_HOLD);

`ifdef WR_PACKER_STATS_EN
  logic [STAT_WIDTH-1:0] r_stall_cnt;
  logic [STAT_WIDTH-1:0] r_word_cnt;

  // Saturating counters of stalled cycles and written words
  always_ff @(posedge wr_clk or negedge wr_rstn) begin
    if (!wr_rstn) begin
      r_stall_cnt <= '0;
      r_word_cnt  <= '0;
    end else if (i_clr) begin
      r_stall_cnt <= '0;
      r_word_cnt  <= '0;
    end else begin
      if ((r_state == OUT_HOLD) && s_if.fifo_full && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + STAT_WIDTH'(1);
      end
      if (w_wr_fire && (r_word_cnt != '1)) begin
        r_word_cnt <= r_word_cnt + STAT_WIDTH'(1);
      end
    end
  end

  assign o_stall_cnt = r_stall_cnt;
  assign o_word_cnt  = r_word_cnt;
`else
  assign o_stall_cnt = '0;
  assign o_word_cnt  = '0;
`endif

endmodule

// File: tb/tb_conv_fifo_wr_packer.sv
// Bench for the write-domain packer: randomized pixel stream and full flag, scoreboarded writes.
// Expected words come from a list-based packing model; a negedge monitor pops on every FIFO write.
// Directed sections cover clean packing, padded flush, held full, clear and mid-word reset.
module tb_conv_fifo_wr_packer;

  localparam int         PW  = 8;
  localparam int         PK  = 4;
  localparam int         W   = PW * PK;
  localparam logic [7:0] PAD = 8'hFF;

  typedef struct {
    logic [W-1:0] word;
    logic         last;
  } exp_t;

  logic        wr_clk  = 1'b0;
  logic        wr_rstn = 1'b0;
  logic        clr     = 1'b0;
  logic        frame_done;
  logic        busy;
  logic [15:0] stall_cnt;
  logic [15:0] word_cnt;

  bit   rand_full  = 1'b0;
  bit   full_force = 1'b0;

  int   n_chk  = 0;
  int   n_pass = 0;

  exp_t       exp_q[$];
  logic [7:0] partial[$];
  int         words_pushed = 0;

  bit           fd_exp     = 1'b0;
  bit           prev_stall = 1'b0;
  logic [W-1:0] prev_data  = '0;

  always #5 wr_clk = ~wr_clk;

  conv_fifo_wr_packer_if #(.PIX_WIDTH(PW), .PACK(PK)) bus ();

  conv_fifo_wr_packer #(
    .PIX_WIDTH (PW),
    .PACK      (PK),
    .PAD_VALUE (PAD),
    .STAT_WIDTH(16)
  ) dut (
    .wr_clk      (wr_clk),
    .wr_rstn     (wr_rstn),
    .i_clr       (clr),
    .s_if        (bus),
    .o_frame_done(frame_done),
    .o_busy      (busy),
    .o_stall_cnt (stall_cnt),
    .o_word_cnt  (word_cnt)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  // Reference: collect pixels; a word is PACK pixels or whatever was collected up to s_last
  function automatic void model_pix(input logic [7:0] d, input logic l);
    exp_t e;
    partial.push_back(d);
    if (partial.size() == PK || l) begin
      e.word = {PK{PAD}};
      for (int i = 0; i < partial.size(); i++) e.word[i*PW +: PW] = partial[i];
      e.last = l;
      exp_q.push_back(e);
      partial.delete();
      words_pushed++;
    end
  endfunction

  // FIFO full flag model, updated shortly after each edge
  always @(posedge wr_clk) begin
    #2;
    bus.fifo_full = rand_full ? ($urandom_range(0, 2) == 0) : full_force;
  end

  // Monitor: every FIFO write is checked against the scoreboard
  always @(negedge wr_clk) begin
    bit fd_next;
    fd_next = 1'b0;
    if (!wr_rstn) begin
      fd_exp     = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (fd_exp || frame_done) chk("frame_done", frame_done, fd_exp);
      if (bus.fifo_wr_en && !bus.fifo_full) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", bus.fifo_wr_data, 0);
          n_pass = n_pass; // value kept; failure already recorded if data differs
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("write_data", bus.fifo_wr_data, e.word);
          fd_next = e.last;
        end
        prev_stall = 1'b0;
      end else if (bus.fifo_wr_en && bus.fifo_full) begin
        if (prev_stall) chk("stall_stable", bus.fifo_wr_data, prev_data);
        prev_stall = 1'b1;
        prev_data  = bus.fifo_wr_data;
      end else begin
        prev_stall = 1'b0;
      end
      fd_exp = fd_next;
    end
  end

  // Offer one pixel, wait (bounded) for acceptance; called and returns at posedge+1
  task automatic send_pix(input logic [7:0] d, input logic l, output int waits);
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = l;
    waits = 0;
    @(negedge wr_clk);
    while (!bus.s_ready && waits < 200) begin
      waits++;
      @(negedge wr_clk);
    end
    if (waits >= 200) chk("send_timeout", 1, 0);
    else model_pix(d, l);
    @(posedge wr_clk);
    #1;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || busy) && t < 500) begin
      @(posedge wr_clk);
      t++;
    end
    #1;
    if (t >= 500) chk("drain_timeout", 1, 0);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    partial.delete();
    words_pushed = 0;
    @(posedge wr_clk);
    #1;
    clr = 1'b0;
  endtask

  initial begin
    int w;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    #1;
    chk("rst_s_ready", bus.s_ready, 1);
    chk("rst_wr_en", bus.fifo_wr_en, 0);
    chk("rst_wr_data", bus.fifo_wr_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_word_cnt", word_cnt, 0);
    repeat (2) @(posedge wr_clk);
    #1;
    wr_rstn = 1'b1;
    @(posedge wr_clk);
    #1;

    // Clean packing at full rate
    for (int i = 1; i <= 8; i++) begin
      send_pix(8'(i), 1'b0, w);
      chk("t1_no_wait", w, 0);
    end
    @(negedge wr_clk);
    chk("t1_latency_en", bus.fifo_wr_en, 1);
    chk("t1_word2", bus.fifo_wr_data, 32'h08070605);
    @(posedge wr_clk);
    #1;

    // Six pixels, last on the sixth -> padded second word
    for (int i = 1; i <= 6; i++) send_pix(8'(i), (i == 6), w);
    @(negedge wr_clk);
    chk("t2_pad_word", bus.fifo_wr_data, {PAD, PAD, 8'h06, 8'h05});
    @(posedge wr_clk);
    #1;
    repeat (2) @(posedge wr_clk);
    #1;

    // Single pixel frame
    send_pix(8'hAA, 1'b1, w);
    @(negedge wr_clk);
    chk("t4_single", bus.fifo_wr_data, 32'hFFFFFFAA);
    @(posedge wr_clk);
    #1;

    // Clear after two pixels drops them
    send_pix(8'h31, 1'b0, w);
    send_pix(8'h32, 1'b0, w);
    do_clr();
    chk("t5_busy_after_clr", busy, 0);
    for (int i = 0; i < 4; i++) send_pix(8'h11 + 8'(i), 1'b0, w);
    @(negedge wr_clk);
    chk("t5_word", bus.fifo_wr_data, 32'h14131211);
    @(posedge wr_clk);
    #1;

    // Held full with a pending word
    wait_drain();
    do_clr();
    full_force = 1'b1;
    for (int i = 0; i < 4; i++) send_pix(8'h21 + 8'(i), 1'b0, w);
    for (int k = 0; k < 10; k++) begin
      @(negedge wr_clk);
      chk("t3_hold_en", bus.fifo_wr_en, 1);
      chk("t3_hold_data", bus.fifo_wr_data, 32'h24232221);
      chk("t3_hold_rdy", bus.s_ready, 0);
    end
    @(posedge wr_clk);
    #1;
    full_force = 1'b0;
    for (int i = 0; i < 4; i++) send_pix(8'h25 + 8'(i), (i == 3), w);
    wait_drain();
`ifdef WR_PACKER_STATS_EN
    chk("t3_stall_cnt", stall_cnt, 10);
    chk("t3_word_cnt", word_cnt, words_pushed);
`else
    chk("t3_stall_cnt", stall_cnt, 0);
    chk("t3_word_cnt", word_cnt, 0);
`endif

    // Randomized stream with random gaps, frame ends and full flag
    rand_full = 1'b1;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge wr_clk);
        #1;
      end
      send_pix(8'($urandom), (n == 399) || ($urandom_range(0, 7) == 0), w);
    end
    rand_full  = 1'b0;
    full_force = 1'b0;
    wait_drain();
    chk("rand_drained", exp_q.size(), 0);
`ifdef WR_PACKER_STATS_EN
    chk("rand_word_cnt", word_cnt, words_pushed);
`endif

    // Reset while a word is stuck behind full: nothing may be written
    full_force = 1'b1;
    for (int i = 0; i < 4; i++) send_pix(8'h41 + 8'(i), 1'b0, w);
    @(negedge wr_clk);
    chk("t6_pending", bus.fifo_wr_en, 1);
    #2;
    exp_q.delete();
    partial.delete();
    words_pushed = 0;
    wr_rstn = 1'b0;
    #1;
    chk("t6_s_ready", bus.s_ready, 1);
    chk("t6_wr_en", bus.fifo_wr_en, 0);
    chk("t6_wr_data", bus.fifo_wr_data, 0);
    chk("t6_busy", busy, 0);
    chk("t6_frame_done", frame_done, 0);
    chk("t6_stall_cnt", stall_cnt, 0);
    chk("t6_word_cnt", word_cnt, 0);
    full_force = 1'b0;
    repeat (3) @(posedge wr_clk);
    #1;
    wr_rstn = 1'b1;
    repeat (6) @(posedge wr_clk);
    #1;
    chk("t6_no_write", exp_q.size(), 0);
    chk("t6_idle_en", bus.fifo_wr_en, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
